// File: rtl/qt_pkg.sv
// Shared constants and types for the UART step controller.
// Holds command bytes, FSM states and a sizing helper.
package qt_pkg;

    localparam logic [7:0] CMD_STEP  = 8'h70;
    localparam logic [7:0] CMD_BURST = 8'h6E;
    localparam logic [7:0] CMD_RUN   = 8'h67;
    localparam logic [7:0] CMD_STOP  = 8'h73;
    localparam logic [7:0] CMD_RST   = 8'h72;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_HIGH,
        S_LOW,
        S_RST
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qt_step_ctrl_if.sv
// Byte stream from the UART receiver into the step controller.
interface qt_step_ctrl_if;

    logic       rx_done;
    logic [7:0] rx_data;

    modport master (output rx_done, output rx_data);
    modport slave  (input  rx_done, input  rx_data);

endinterface

// File: rtl/qt_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module qt_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/qt_step_ctrl.sv
// Command-driven step clock / reset generator for the CPU under test.
module qt_step_ctrl
    import qt_pkg::*;
#(
    parameter int PULSE_CYCLES = 25_000_000,
    parameter int GAP_CYCLES   = 25_000_000,
    parameter int RST_CYCLES   = 16,
    parameter int CNT_W        = 8,
    parameter int STEP_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    qt_step_ctrl_if.slave     rx,
    output logic              sclk,
    output logic              sresetn,
    output logic              busy,
    output logic              run_mode,
    output logic [STEP_W-1:0] step_count
);

    localparam int MAXC = max3(PULSE_CYCLES, GAP_CYCLES, RST_CYCLES);
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] P_LD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] G_LD = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] R_LD = TW'(RST_CYCLES - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  rem, rem_val;
    logic [STEP_W-1:0] steps;
    logic              run, stop_req;
    logic              ld, t_done;
    logic [TW-1:0]     ld_val;
    logic              rem_ld, set_run, set_stop;
    logic              clr, step, rst_go;
    logic              c_p, c_n, c_g, c_s, c_r;

    assign c_p = rx.rx_done && (rx.rx_data == CMD_STEP);
    assign c_n = rx.rx_done && (rx.rx_data == CMD_BURST);
    assign c_g = rx.rx_done && (rx.rx_data == CMD_RUN);
    assign c_s = rx.rx_done && (rx.rx_data == CMD_STOP);
    assign c_r = rx.rx_done && (rx.rx_data == CMD_RST);
    assign rem_val = CNT_W'(rx.rx_data);

    qt_phase_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (ld),
        .val   (ld_val),
        .done  (t_done)
    );

    always_comb begin
        state_n  = state;
        ld       = 1'b0;
        ld_val   = P_LD;
        rem_ld   = 1'b0;
        set_run  = 1'b0;
        set_stop = 1'b0;
        clr      = 1'b0;
        step     = 1'b0;
        rst_go   = 1'b0;
        unique case (state)
            S_IDLE: begin
                unique case (1'b1)
                    c_p: begin
                        state_n = S_HIGH;
                        ld      = 1'b1;
                        rem_ld  = 1'b1;
                    end
                    c_n: state_n = S_ARG;
                    c_g: begin
                        state_n = S_HIGH;
                        ld      = 1'b1;
                        set_run = 1'b1;
                    end
                    c_r: begin
                        state_n = S_RST;
                        ld      = 1'b1;
                        ld_val  = R_LD;
                        rst_go  = 1'b1;
                    end
                    default: ;
                endcase
            end
            // Any byte here is the burst length, reset byte included.
            S_ARG: begin
                if (rx.rx_done) begin
                    if (rem_val == '0) begin
                        state_n = S_IDLE;
                        clr     = 1'b1;
                    end else begin
                        state_n = S_HIGH;
                        ld      = 1'b1;
                        rem_ld  = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (c_r) begin
                    state_n = S_RST;
                    ld      = 1'b1;
                    ld_val  = R_LD;
                    rst_go  = 1'b1;
                end else begin
                    set_stop = c_s;
                    if (t_done) begin
                        step = 1'b1;
                        if ((rem == CNT_W'(1) && !run) || stop_req || c_s) begin
                            state_n = S_IDLE;
                            clr     = 1'b1;
                        end else begin
                            state_n = S_LOW;
                            ld      = 1'b1;
                            ld_val  = G_LD;
                        end
                    end
                end
            end
            S_LOW: begin
                if (c_r) begin
                    state_n = S_RST;
                    ld      = 1'b1;
                    ld_val  = R_LD;
                    rst_go  = 1'b1;
                end else if (stop_req || c_s) begin
                    state_n = S_IDLE;
                    clr     = 1'b1;
                end else if (t_done) begin
                    state_n = S_HIGH;
                    ld      = 1'b1;
                end
            end
            S_RST: begin
                if (t_done) begin
                    state_n = S_IDLE;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rem      <= '0;
            steps    <= '0;
            run      <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            state <= state_n;
            if (rst_go) begin
                rem      <= '0;
                steps    <= '0;
                run      <= 1'b0;
                stop_req <= 1'b0;
            end else begin
                if (clr) begin
                    run      <= 1'b0;
                    stop_req <= 1'b0;
                end else begin
                    if (set_run)  run      <= 1'b1;
                    if (set_stop) stop_req <= 1'b1;
                end
                if (rem_ld)    rem <= (state == S_IDLE) ? CNT_W'(1) : rem_val;
                else if (step) rem <= rem - 1'b1;
                if (step)      steps <= steps + 1'b1;
            end
        end
    end

    // Outputs are a registered image of the state, one edge behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk       <= 1'b0;
            sresetn    <= 1'b1;
            busy       <= 1'b0;
            run_mode   <= 1'b0;
            step_count <= '0;
        end else begin
            sclk       <= (state == S_HIGH);
            sresetn    <= (state != S_RST);
            busy       <= (state != S_IDLE);
            run_mode   <= run;
            step_count <= steps;
        end
    end

endmodule
